fifo_burst_reader: RTL and testbench

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

---
 rtl/fifo_burst_reader.sv | 146 ++++++++++++++
 tb/tb_fifo_burst_reader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Burst reader: pulls burst_len words from a sync FIFO (1-cycle read latency)
// into a 2-entry skid buffer and presents them on a valid/ready stream.
module fifo_burst_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            burst_len,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           beat_count
);

  if (DEPTH == 0) begin : g_depth_check
    $error("fifo_burst_reader: DEPTH must be non-zero");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            issued_q, issued_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic [15:0]           beat_q, beat_d;

  logic                  push;
  logic                  pop;
  logic                  rd_en;
  logic [2:0]            pending;

  always_comb begin
    pop     = (occ_q != 2'd0) & m_ready;
    push    = inflight_q;
    pending = {1'b0, occ_q} + {2'b00, inflight_q};
    // Written as pending < 2 + pop to keep the "occ + inflight - pop < 2" test unsigned.
    rd_en   = (state_q == ST_RUN) && !fifo_empty && (issued_q < len_q)
              && (pending < (3'd2 + {2'b00, pop}));

    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    inflight_d = rd_en;
    occ_d      = occ_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    beat_d     = beat_q + {15'd0, pop};

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d    = burst_len;
          issued_d = '0;
          state_d  = (burst_len != 8'd0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (rd_en) begin
          issued_d = issued_q + 8'd1;
        end
        if (issued_d == len_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((occ_q == 2'd0) && !inflight_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // buf0 is always the oldest entry; a pop shifts buf1 down.
    unique case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          buf0_d = fifo_data;
        end else begin
          buf1_d = fifo_data;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = fifo_data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      occ_q      <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      beat_q     <= beat_d;
    end
  end

  assign fifo_rd_en = rd_en;
  assign m_valid    = (occ_q != 2'd0);
  assign m_data     = buf0_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign beat_count = beat_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: cycle-vector table for a basic burst,
// then hand-written sequences for stalls, FIFO underrun, zero length, reset and wrap.
module tb_fifo_burst_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  burst_len;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  fifo_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        busy;
  logic        done;
  logic [15:0] beat_count;

  int n_assert = 0;
  int n_fail   = 0;

  fifo_burst_reader #(.DATA_WIDTH(8), .DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .burst_len  (burst_len),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy),
    .done       (done),
    .beat_count (beat_count)
  );

  always #5 clk = ~clk;

  // Behavioural sync FIFO with one-cycle read latency; flushed by rst.
  logic [7:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int underflow = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en) begin
      if (fifo_empty) begin
        underflow <= underflow + 1;
      end else begin
        fifo_data <= mem[rd_ptr % 1024];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  task automatic push_fifo(input logic [7:0] d);
    mem[wr_ptr % 1024] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  // Stream monitor: records accepted words, done pulses, reads and hold violations.
  logic [7:0] got [$];
  int   done_cnt  = 0;
  int   rd_cnt    = 0;
  int   hold_viol = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!m_valid || (m_data !== prev_data))) hold_viol <= hold_viol + 1;
      if (m_valid && m_ready) got.push_back(m_data);
      if (done) done_cnt <= done_cnt + 1;
      if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
      prev_stall <= m_valid && !m_ready;
      prev_data  <= m_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_burst(input logic [7:0] len);
    start     = 1'b1;
    burst_len = len;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    check({name, " done_seen"}, (n < budget), 1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        start;
    logic [7:0]  len;
    logic        ready;
    logic        rd;
    logic        valid;
    logic [7:0]  data;
    logic        chk_data;
    logic        busy;
    logic        done;
    logic [15:0] beats;
  } vec_t;

  vec_t vt [11];

  initial begin
    int base;
    int d0;
    int rc0;
    int exp_beats;
    int n;
    int at_done;
    int busy_low;
    logic seen;

    // start, len, ready | rd, valid, data, chk_data, busy, done, beats
    vt[0]  = '{1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0};
    vt[1]  = '{1'b0, 8'd2, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'd0};
    vt[2]  = '{1'b0, 8'd2, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'd0};
    vt[3]  = '{1'b0, 8'd2, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 16'd0};
    vt[4]  = '{1'b0, 8'd2, 1'b1, 1'b1, 1'b1, 8'h12, 1'b1, 1'b1, 1'b0, 16'd1};
    vt[5]  = '{1'b0, 8'd2, 1'b1, 1'b1, 1'b1, 8'h13, 1'b1, 1'b1, 1'b0, 16'd2};
    vt[6]  = '{1'b1, 8'd2, 1'b1, 1'b0, 1'b1, 8'h14, 1'b1, 1'b1, 1'b0, 16'd3};
    vt[7]  = '{1'b0, 8'd2, 1'b1, 1'b0, 1'b1, 8'h15, 1'b1, 1'b1, 1'b0, 16'd4};
    vt[8]  = '{1'b0, 8'd2, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'd5};
    vt[9]  = '{1'b1, 8'd2, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 16'd5};
    vt[10] = '{1'b0, 8'd2, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd5};

    rst = 1'b1; start = 1'b0; burst_len = 8'd0; m_ready = 1'b0;
    @(negedge clk);
    check("reset rd_en", fifo_rd_en, 0);
    check("reset m_valid", m_valid, 0);
    check("reset m_data", m_data, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset beat_count", beat_count, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic 5-word burst, cycle by cycle; burst_len/start changes mid-burst are ignored.
    for (int i = 0; i < 5; i++) push_fifo(8'h11 + 8'(i));
    for (int i = 0; i < 11; i++) begin
      start = vt[i].start; burst_len = vt[i].len; m_ready = vt[i].ready;
      @(negedge clk);
      check($sformatf("vec%0d rd_en", i), fifo_rd_en, vt[i].rd);
      check($sformatf("vec%0d m_valid", i), m_valid, vt[i].valid);
      if (vt[i].chk_data) check($sformatf("vec%0d m_data", i), m_data, vt[i].data);
      check($sformatf("vec%0d busy", i), busy, vt[i].busy);
      check($sformatf("vec%0d done", i), done, vt[i].done);
      check($sformatf("vec%0d beat_count", i), beat_count, vt[i].beats);
      @(posedge clk); #1;
    end
    start = 1'b0;
    exp_beats = 5;

    // 4-word burst with m_ready toggling every cycle.
    base = got.size(); d0 = done_cnt; seen = 1'b0; at_done = 0; n = 0;
    for (int i = 0; i < 4; i++) push_fifo(8'h21 + 8'(i));
    m_ready = 1'b1;
    start_burst(8'd4);
    while (n < 100 && !seen) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; at_done = got.size() - base; end
      @(posedge clk); #1;
      m_ready = ~m_ready;
      n++;
    end
    m_ready = 1'b1;
    check("toggle done_seen", seen, 1);
    check("toggle beats_before_done", at_done, 4);
    check("toggle word_count", got.size() - base, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("toggle word%0d", i), got[base + i], 8'h21 + 8'(i));
    check("toggle done_pulses", done_cnt - d0, 1);
    exp_beats += 4;
    check("toggle beat_count", beat_count, exp_beats);
    check("toggle hold_stable", hold_viol, 0);

    // FIFO runs dry after 2 of 6 words, refilled later.
    base = got.size(); d0 = done_cnt; busy_low = 0;
    push_fifo(8'h31); push_fifo(8'h32);
    start_burst(8'd6);
    repeat (12) begin
      @(negedge clk);
      if (!busy) busy_low++;
      @(posedge clk); #1;
    end
    check("underrun busy_held", busy_low, 0);
    check("underrun partial_words", got.size() - base, 2);
    for (int i = 0; i < 4; i++) push_fifo(8'h33 + 8'(i));
    wait_done(50, "underrun");
    check("underrun word_count", got.size() - base, 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("underrun word%0d", i), got[base + i], 8'h31 + 8'(i));
    check("underrun done_pulses", done_cnt - d0, 1);
    exp_beats += 6;
    check("underrun beat_count", beat_count, exp_beats);

    // Zero-length burst.
    rc0 = rd_cnt; d0 = done_cnt;
    start = 1'b1; burst_len = 8'd0;
    @(negedge clk);
    check("zero start_cycle done", done, 0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("zero done_pulse", done, 1);
    check("zero busy", busy, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("zero done_low", done, 0);
    check("zero busy_low", busy, 0);
    check("zero no_reads", rd_cnt - rc0, 0);
    check("zero done_pulses", done_cnt - d0, 1);
    check("zero beat_count", beat_count, exp_beats);
    @(posedge clk); #1;

    // Reset while the skid buffer is full in RUN, then a fresh 3-word burst.
    for (int i = 0; i < 8; i++) push_fifo(8'h50 + 8'(i));
    m_ready = 1'b0;
    start_burst(8'd8);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("full m_valid", m_valid, 1);
    check("full m_data", m_data, 8'h50);
    check("full rd_en_blocked", fifo_rd_en, 0);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("async_rst m_valid", m_valid, 0);
    check("async_rst busy", busy, 0);
    check("async_rst rd_en", fifo_rd_en, 0);
    check("async_rst beat_count", beat_count, 0);
    @(posedge clk); #1 rst = 1'b0;
    exp_beats = 0;
    base = got.size(); d0 = done_cnt;
    for (int i = 0; i < 3; i++) push_fifo(8'h41 + 8'(i));
    m_ready = 1'b1;
    start_burst(8'd3);
    wait_done(30, "post_rst");
    check("post_rst word_count", got.size() - base, 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("post_rst word%0d", i), got[base + i], 8'h41 + 8'(i));
    check("post_rst done_pulses", done_cnt - d0, 1);
    exp_beats += 3;
    check("post_rst beat_count", beat_count, exp_beats);

    // beat_count wrap: 257 x 255 = 65535 beats, then one more.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int b = 0; b < 257; b++) begin
      for (int k = 0; k < 255; k++) push_fifo(8'(b + k));
      start_burst(8'd255);
      wait_done(400, $sformatf("wrap burst%0d", b));
    end
    check("wrap beat_count_ffff", beat_count, 16'hFFFF);
    push_fifo(8'hA5);
    start_burst(8'd1);
    wait_done(30, "wrap last");
    check("wrap beat_count_zero", beat_count, 16'h0000);
    check("fifo no_underflow", underflow, 0);
    check("stream hold_stable", hold_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
